aes_in_loader: RTL and testbench



---
 rtl/aes_in_loader.sv | 173 +++++++++++++++++
 tb/tb_aes_in_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_in_loader.sv
// Byte-serial loader feeding the AES pipeline register stage.
// Collects 16 plaintext bytes then 16 key bytes, then presents them in parallel for one clock.
module aes_in_loader #(
  parameter logic [7:0] RCON_INIT = 8'h01,
  parameter int         CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  input  logic             flush,
  output logic [7:0]       out0,
  output logic [7:0]       out1,
  output logic [7:0]       out2,
  output logic [7:0]       out3,
  output logic [7:0]       out4,
  output logic [7:0]       out5,
  output logic [7:0]       out6,
  output logic [7:0]       out7,
  output logic [7:0]       out8,
  output logic [7:0]       out9,
  output logic [7:0]       outA,
  output logic [7:0]       outB,
  output logic [7:0]       outC,
  output logic [7:0]       outD,
  output logic [7:0]       outE,
  output logic [7:0]       outF,
  output logic [7:0]       outk0,
  output logic [7:0]       outk1,
  output logic [7:0]       outk2,
  output logic [7:0]       outk3,
  output logic [7:0]       outk4,
  output logic [7:0]       outk5,
  output logic [7:0]       outk6,
  output logic [7:0]       outk7,
  output logic [7:0]       outk8,
  output logic [7:0]       outk9,
  output logic [7:0]       outkA,
  output logic [7:0]       outkB,
  output logic [7:0]       outkC,
  output logic [7:0]       outkD,
  output logic [7:0]       outkE,
  output logic [7:0]       outkF,
  output logic             empty,
  output logic [7:0]       Rcon_out,
  output logic [CNT_W-1:0] blk_cnt
);

  // state | meaning
  // LOAD  | accepting bytes into the shadow registers
  // ISSUE | assembled block is on the outputs with empty=0
  typedef enum logic {LOAD, ISSUE} state_t;

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;
  logic       ready_nxt, empty_nxt;
  logic [7:0] rcon_nxt;
  logic       sh_we, issue_go;
  logic       accept;

  logic [7:0] sh_st [16];
  logic [7:0] sh_k  [15];
  logic [7:0] ob_st [16];
  logic [7:0] ob_k  [16];

  assign accept = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ready_nxt = in_ready;
    empty_nxt = 1'b1;
    rcon_nxt  = 8'h00;
    sh_we     = 1'b0;
    issue_go  = 1'b0;
    case (state)
      LOAD: begin
        ready_nxt = 1'b1;
        if (flush) begin
          idx_nxt = 5'd0;
        end else if (accept) begin
          if (idx == 5'd31) begin
            issue_go  = 1'b1;
            ready_nxt = 1'b0;
            empty_nxt = 1'b0;
            rcon_nxt  = RCON_INIT;
            idx_nxt   = 5'd0;
            state_nxt = ISSUE;
          end else begin
            sh_we   = 1'b1;
            idx_nxt = idx + 5'd1;
          end
        end
      end
      ISSUE: begin
        ready_nxt = 1'b1;
        state_nxt = LOAD;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= LOAD;
      idx      <= 5'd0;
      in_ready <= 1'b0;
      empty    <= 1'b1;
      Rcon_out <= 8'h00;
      blk_cnt  <= '0;
      for (int i = 0; i < 16; i++) begin
        sh_st[i] <= 8'h00;
        ob_st[i] <= 8'h00;
        ob_k[i]  <= 8'h00;
      end
      for (int i = 0; i < 15; i++) sh_k[i] <= 8'h00;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      in_ready <= ready_nxt;
      empty    <= empty_nxt;
      Rcon_out <= rcon_nxt;
      if (sh_we) begin
        if (!idx[4]) sh_st[idx[3:0]] <= in_byte;
        else         sh_k[idx[3:0]]  <= in_byte;
      end
      // Last key byte bypasses the shadow so the block issues one cycle after its final accept.
      if (issue_go) begin
        for (int i = 0; i < 16; i++) ob_st[i] <= sh_st[i];
        for (int i = 0; i < 15; i++) ob_k[i]  <= sh_k[i];
        ob_k[15] <= in_byte;
        blk_cnt  <= blk_cnt + CNT_W'(1);
      end
    end
  end

  assign out0  = ob_st[0];
  assign out1  = ob_st[1];
  assign out2  = ob_st[2];
  assign out3  = ob_st[3];
  assign out4  = ob_st[4];
  assign out5  = ob_st[5];
  assign out6  = ob_st[6];
  assign out7  = ob_st[7];
  assign out8  = ob_st[8];
  assign out9  = ob_st[9];
  assign outA  = ob_st[10];
  assign outB  = ob_st[11];
  assign outC  = ob_st[12];
  assign outD  = ob_st[13];
  assign outE  = ob_st[14];
  assign outF  = ob_st[15];
  assign outk0 = ob_k[0];
  assign outk1 = ob_k[1];
  assign outk2 = ob_k[2];
  assign outk3 = ob_k[3];
  assign outk4 = ob_k[4];
  assign outk5 = ob_k[5];
  assign outk6 = ob_k[6];
  assign outk7 = ob_k[7];
  assign outk8 = ob_k[8];
  assign outk9 = ob_k[9];
  assign outkA = ob_k[10];
  assign outkB = ob_k[11];
  assign outkC = ob_k[12];
  assign outkD = ob_k[13];
  assign outkE = ob_k[14];
  assign outkF = ob_k[15];

endmodule

// File: tb/tb_aes_in_loader.sv
// Bench for aes_in_loader: a byte-queue reference model predicts every output each cycle.
// A second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_aes_in_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        flush = 1'b0;
  logic        in_ready, empty, in_ready2, empty2;
  logic [7:0]  rcon, rcon2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic [7:0]  s1 [16];
  logic [7:0]  k1 [16];
  logic [7:0]  s2 [16];
  logic [7:0]  k2 [16];

  always #5 clock = ~clock;

  aes_in_loader dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .flush(flush),
    .out0(s1[0]), .out1(s1[1]), .out2(s1[2]), .out3(s1[3]),
    .out4(s1[4]), .out5(s1[5]), .out6(s1[6]), .out7(s1[7]),
    .out8(s1[8]), .out9(s1[9]), .outA(s1[10]), .outB(s1[11]),
    .outC(s1[12]), .outD(s1[13]), .outE(s1[14]), .outF(s1[15]),
    .outk0(k1[0]), .outk1(k1[1]), .outk2(k1[2]), .outk3(k1[3]),
    .outk4(k1[4]), .outk5(k1[5]), .outk6(k1[6]), .outk7(k1[7]),
    .outk8(k1[8]), .outk9(k1[9]), .outkA(k1[10]), .outkB(k1[11]),
    .outkC(k1[12]), .outkD(k1[13]), .outkE(k1[14]), .outkF(k1[15]),
    .empty(empty), .Rcon_out(rcon), .blk_cnt(cnt)
  );

  aes_in_loader #(.RCON_INIT(8'h01), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready2), .flush(flush),
    .out0(s2[0]), .out1(s2[1]), .out2(s2[2]), .out3(s2[3]),
    .out4(s2[4]), .out5(s2[5]), .out6(s2[6]), .out7(s2[7]),
    .out8(s2[8]), .out9(s2[9]), .outA(s2[10]), .outB(s2[11]),
    .outC(s2[12]), .outD(s2[13]), .outE(s2[14]), .outF(s2[15]),
    .outk0(k2[0]), .outk1(k2[1]), .outk2(k2[2]), .outk3(k2[3]),
    .outk4(k2[4]), .outk5(k2[5]), .outk6(k2[6]), .outk7(k2[7]),
    .outk8(k2[8]), .outk9(k2[9]), .outkA(k2[10]), .outkB(k2[11]),
    .outkC(k2[12]), .outkD(k2[13]), .outkE(k2[14]), .outkF(k2[15]),
    .empty(empty2), .Rcon_out(rcon2), .blk_cnt(cnt2)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [7:0] a [16]);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
    return r;
  endfunction

  // reference model: bytes accepted so far for the current block, plus last issued block
  logic [7:0]   q [$];
  bit           m_ready;
  bit           m_issue;
  logic [127:0] m_st, m_k;
  int           m_cnt;
  int           cyc;
  int           issue_t [$];

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
    m_issue = 1'b0;
    m_st    = '0;
    m_k     = '0;
    m_cnt   = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", 128'(in_ready), 128'(m_ready));
    chk("empty", 128'(empty), 128'(!m_issue));
    chk("rcon", 128'(rcon), m_issue ? 128'h01 : 128'h00);
    chk("blk_cnt", 128'(cnt), 128'(m_cnt % 65536));
    chk("blk_cnt_w2", 128'(cnt2), 128'(m_cnt % 4));
    chk("state_bytes", pk(s1), m_st);
    chk("key_bytes", pk(k1), m_k);
    chk("empty_w2", 128'(empty2), 128'(!m_issue));
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit f);
    bit acc;
    in_valid = v;
    in_byte  = b;
    flush    = f;
    acc      = v && m_ready;
    @(posedge clock);
    cyc++;
    if (m_issue) begin
      m_issue = 1'b0;
      m_ready = 1'b1;
    end else begin
      m_ready = 1'b1;
      if (f) begin
        q.delete();
      end else if (acc) begin
        q.push_back(b);
        if (q.size() == 32) begin
          for (int i = 0; i < 16; i++) begin
            m_st[127-8*i -: 8] = q[i];
            m_k[127-8*i -: 8]  = q[16+i];
          end
          q.delete();
          m_issue = 1'b1;
          m_ready = 1'b0;
          m_cnt++;
          issue_t.push_back(cyc);
        end
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  // present one byte until accepted; gap inserts an idle cycle before it
  task automatic send(input logic [7:0] b, input bit gap);
    bit a;
    int n;
    if (gap) step(1'b0, 8'($urandom), 1'b0);
    n = 0;
    do begin
      a = m_ready;
      step(1'b1, b, 1'b0);
      n++;
    end while (!a && n < 40);
    if (!a) chk("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_rcon", 128'(rcon), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(0));
    chk("rst_state", pk(s1), 128'(0));
    chk("rst_key", pk(k1), 128'(0));
    chk("rst_cnt", 128'(cnt), 128'(0));
    model_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1 chk("rel_ready", 128'(in_ready), 128'(0));
  endtask

  logic [7:0] fips_pt [16];
  logic [7:0] fips_k  [16];

  initial begin
    cyc = 0;
    model_reset();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fips_pt[i] = 8'(i * 17);
      fips_k[i]  = 8'(i);
    end

    do_reset();
    step(1'b0, 8'h00, 1'b0);

    // back-to-back incrementing stream
    for (int i = 0; i < 32; i++) send(8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_out0", 128'(s1[0]), 128'h00);
    chk("t1_outkF", 128'(k1[15]), 128'h1f);

    // alternate-cycle gaps
    for (int i = 0; i < 32; i++) send(8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // partial load, flush with valid high, then FIPS-197 vector
    for (int i = 0; i < 10; i++) send(8'hA0 + 8'(i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 16; i++) send(fips_pt[i], 1'b0);
    for (int i = 0; i < 16; i++) send(fips_k[i], 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("fips_out0", 128'(s1[0]), 128'h00);
    chk("fips_outF", 128'(s1[15]), 128'hff);
    chk("fips_outk0", 128'(k1[0]), 128'h00);
    chk("fips_outkF", 128'(k1[15]), 128'h0f);

    // reset in the middle of a load, then a full load
    for (int i = 0; i < 20; i++) send(8'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 32; i++) send(8'hC0 ^ 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // back-to-back blocks from a fresh reset: spacing and counter wrap
    do_reset();
    issue_t.delete();
    for (int i = 0; i < 5 * 32; i++) send(8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_nissue", 128'(issue_t.size()), 128'(5));
    for (int i = 0; i + 1 < issue_t.size(); i++)
      chk("t5_spacing", 128'(issue_t[i+1] - issue_t[i]), 128'(33));
    chk("t6_cnt_w2", 128'(cnt2), 128'(1));

    // randomized valid/byte/flush
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 63) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finished", total);
    $fatal(1, "timeout");
  end

endmodule
